fu_sequencer: RTL and testbench

- Issue-side controller for the 16-bit function unit: accepts one instruction at a time over a valid/ready handshake.
- Reads operands from an internal 8x16 register file and drives FS/A/B to the function unit.
- Captures result plus V/C/N/Z, writes the result back and holds the status flags in a register.
- Sits between the instruction source (fetch/test harness) and the function unit; the function unit is purely combinational and tri-stated when FS decodes to no operation.

---
 rtl/fu_sequencer_if.sv | 9 +
 rtl/fu_sequencer.sv | 135 +++++++++++++
 tb/tb_fu_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_sequencer_if.sv
// Instruction handshake between the instruction source (master) and fu_sequencer (slave).
interface fu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/fu_sequencer.sv
// Issue-side controller for the 16-bit function unit: IDLE -> EXEC -> WB, 8x16 register file, V/C/N/Z flags.
// Optional macro FU_SEQ_COND_EN: instr[2:0] becomes a flag condition that gates write-back.
module fu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int FS_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fu_sequencer_if.slave            instr_bus,
  input  logic                     ld_valid,
  input  logic [$clog2(NREG)-1:0]  ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [$clog2(NREG)-1:0]  rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [FS_W-1:0]          fu_fs,
  output logic [DATA_W-1:0]        fu_a,
  output logic [DATA_W-1:0]        fu_b,
  input  logic [DATA_W-1:0]        fu_result,
  input  logic                     fu_v,
  input  logic                     fu_c,
  input  logic                     fu_n,
  input  logic                     fu_z,
  output logic [3:0]               flags,
  output logic                     done,
  output logic                     err
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREG];
  logic [AW-1:0]     rd_p0;
  logic [DATA_W-1:0] result_p1;
  logic [3:0]        status_p1;
  logic              wb_en_p1;
  logic              legal;
  logic              cond_ok;

  function automatic logic fs_legal(input logic [FS_W-1:0] fs);
    return (fs != 4'h0) && (fs != 4'hE) && (fs != 4'hF);
  endfunction

`ifdef FU_SEQ_COND_EN
  logic [2:0] cond_p0;

  // f is {V,C,N,Z}
  function automatic logic cond_pass(input logic [2:0] cond, input logic [3:0] f);
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return f[0];
      3'd2:    return !f[0];
      3'd3:    return f[1];
      3'd4:    return !f[1];
      3'd5:    return f[2];
      3'd6:    return f[3];
      default: return 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_pass(cond_p0, flags);
`else
  logic unused_cond;
  assign unused_cond = ^instr_bus.instr[2:0];
  assign cond_ok     = 1'b1;
`endif

  assign legal                 = fs_legal(fu_fs);
  assign rd_data               = regs[rd_addr];
  assign instr_bus.instr_ready = rst_n && (state == IDLE) && !ld_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      rd_p0     <= '0;
      result_p1 <= '0;
      status_p1 <= '0;
      wb_en_p1  <= 1'b0;
      fu_fs     <= '0;
      fu_a      <= '0;
      fu_b      <= '0;
      flags     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef FU_SEQ_COND_EN
      cond_p0   <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        // Stage p0: direct load has priority over accepting an instruction
        IDLE: begin
          if (ld_valid) begin
            regs[ld_addr] <= ld_data;
          end else if (instr_bus.instr_valid) begin
            fu_fs <= instr_bus.instr[15:12];
            rd_p0 <= instr_bus.instr[11:9];
            fu_a  <= regs[instr_bus.instr[8:6]];
            fu_b  <= regs[instr_bus.instr[5:3]];
`ifdef FU_SEQ_COND_EN
            cond_p0 <= instr_bus.instr[2:0];
`endif
            state <= EXEC;
          end
        end
        // Stage p1: function unit is driven this cycle; sample only for legal codes
        EXEC: begin
          if (legal) begin
            result_p1 <= fu_result;
            status_p1 <= {fu_v, fu_c, fu_n, fu_z};
          end
          wb_en_p1 <= legal && cond_ok;
          done     <= 1'b1;
          err      <= !legal && cond_ok;
          fu_fs    <= '0;
          fu_a     <= '0;
          fu_b     <= '0;
          state    <= WB;
        end
        // Stage p2: retire
        WB: begin
          if (wb_en_p1) begin
            regs[rd_p0] <= result_p1;
            flags       <= status_p1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fu_sequencer.sv
// Directed self-checking bench for fu_sequencer with a small behavioural function-unit model.
module tb_fu_sequencer;
  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [3:0]  fu_fs;
  logic [15:0] fu_a, fu_b, fu_result;
  logic        fu_v, fu_c, fu_n, fu_z;
  logic [3:0]  flags;
  logic        done, err;
  logic [16:0] tmp;

  int total = 0;
  int bad   = 0;

  fu_sequencer_if ibus();

  fu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_bus(ibus),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .fu_fs(fu_fs), .fu_a(fu_a), .fu_b(fu_b), .fu_result(fu_result),
    .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
    .flags(flags), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function unit model for the codes exercised here
  always_comb begin
    tmp       = '0;
    fu_result = '0;
    fu_v      = 1'b0;
    fu_c      = 1'b0;
    fu_n      = 1'b0;
    fu_z      = 1'b0;
    case (fu_fs)
      4'h1: begin
        tmp       = {1'b0, fu_a} + {1'b0, fu_b};
        fu_result = tmp[15:0];
        fu_c      = tmp[16];
        fu_v      = (fu_a[15] == fu_b[15]) && (tmp[15] != fu_a[15]);
        fu_n      = tmp[15];
        fu_z      = (tmp[15:0] == 16'h0);
      end
      4'h2: begin
        fu_result = fu_a - fu_b;
        fu_c      = (fu_a >= fu_b);
        fu_v      = (fu_a[15] != fu_b[15]) && (fu_result[15] != fu_a[15]);
        fu_n      = fu_result[15];
        fu_z      = (fu_result == 16'h0);
      end
      4'h8: begin
        tmp       = {1'b0, fu_a} + 17'd1;
        fu_result = tmp[15:0];
        fu_c      = tmp[16];
        fu_v      = !fu_a[15] && tmp[15];
        fu_n      = tmp[15];
        fu_z      = (tmp[15:0] == 16'h0);
      end
      4'hD: fu_result = {fu_a[7:0], fu_a[15:8]};
      default: ;
    endcase
  end

  function automatic logic [15:0] mk(input logic [3:0] fs, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [2:0] cond);
    return {fs, rd, ra, rb, cond};
  endfunction

  // Stimulus helpers: called and return at a falling edge
  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    ibus.instr_valid = 1'b1; ibus.instr = ins;
    @(negedge clk);
    ibus.instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    load(3'd1, 16'h0001);
    load(3'd2, 16'h0002);
    issue(mk(4'h1, 3'd3, 3'd1, 3'd2, 3'd0));
    total++;
    if (fu_fs !== 4'h1) begin bad++; $display("FAIL rst_pre_exec_fs: got %h want 1", fu_fs); end
    rst_n = 1'b0;
    #1;
    total++;
    if (ibus.instr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low: got %b want 0", ibus.instr_ready); end
    @(negedge clk);
    total++;
    if (flags !== 4'h0) begin bad++; $display("FAIL rst_flags: got %h want 0", flags); end
    total++;
    if (done !== 1'b0 || fu_fs !== 4'h0) begin bad++; $display("FAIL rst_done_fs: got done=%b fs=%h want 0/0", done, fu_fs); end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      total++;
      if (rd_data !== 16'h0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0000", i, rd_data); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ibus.instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_first_idle: got %b want 1", ibus.instr_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL rst_no_done: got %b want 0", done); end
    end
  endtask

  task automatic test_add;
    load(3'd1, 16'hFFFF);
    load(3'd2, 16'h0001);
    issue(mk(4'h1, 3'd3, 3'd1, 3'd2, 3'd0));
    total++;
    if (fu_fs !== 4'h1 || fu_a !== 16'hFFFF || fu_b !== 16'h0001)
      begin bad++; $display("FAIL add_exec_bus: got fs=%h a=%h b=%h want 1/ffff/0001", fu_fs, fu_a, fu_b); end
    total++;
    if (ibus.instr_ready !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL add_exec_ctrl: got ready=%b done=%b want 0/0", ibus.instr_ready, done); end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || fu_fs !== 4'h0)
      begin bad++; $display("FAIL add_wb: got done=%b err=%b fs=%h want 1/0/0", done, err, fu_fs); end
    @(negedge clk);
    rd_addr = 3'd3;
    #1;
    total++;
    if (rd_data !== 16'h0000) begin bad++; $display("FAIL add_r3: got %h want 0000", rd_data); end
    total++;
    if (flags !== 4'b0101) begin bad++; $display("FAIL add_flags: got %b want 0101", flags); end
    total++;
    if (done !== 1'b0 || ibus.instr_ready !== 1'b1)
      begin bad++; $display("FAIL add_idle: got done=%b ready=%b want 0/1", done, ibus.instr_ready); end
  endtask

  task automatic test_illegal;
    issue(mk(4'hE, 3'd1, 3'd1, 3'd2, 3'd0));
    total++;
    if (fu_fs !== 4'hE) begin bad++; $display("FAIL ill_exec_fs: got %h want e", fu_fs); end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL ill_pulse: got done=%b err=%b want 1/1", done, err); end
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ill_err_one_cycle: got %b want 0", err); end
    rd_addr = 3'd1;
    #1;
    total++;
    if (rd_data !== 16'hFFFF) begin bad++; $display("FAIL ill_r1: got %h want ffff", rd_data); end
    total++;
    if (flags !== 4'b0101) begin bad++; $display("FAIL ill_flags: got %b want 0101", flags); end
  endtask

  task automatic test_sub;
    load(3'd1, 16'h8000);
    load(3'd2, 16'h0001);
    issue(mk(4'h2, 3'd4, 3'd1, 3'd2, 3'd0));
    @(negedge clk);
    @(negedge clk);
    rd_addr = 3'd4;
    #1;
    total++;
    if (rd_data !== 16'h7FFF) begin bad++; $display("FAIL sub_r4: got %h want 7fff", rd_data); end
    total++;
    if (flags[3] !== 1'b1 || flags[1] !== 1'b0) begin bad++; $display("FAIL sub_vn: got %b want V=1 N=0", flags); end
  endtask

  task automatic test_swap;
    load(3'd5, 16'h12AB);
    issue(mk(4'hD, 3'd5, 3'd5, 3'd0, 3'd0));
    total++;
    if (fu_a !== 16'h12AB) begin bad++; $display("FAIL swap_operand: got %h want 12ab", fu_a); end
    @(negedge clk);
    @(negedge clk);
    rd_addr = 3'd5;
    #1;
    total++;
    if (rd_data !== 16'hAB12) begin bad++; $display("FAIL swap_r5: got %h want ab12", rd_data); end
    total++;
    if (flags !== 4'b0000) begin bad++; $display("FAIL swap_flags: got %b want 0000", flags); end
  endtask

  task automatic test_load_priority;
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h5A5A;
    ibus.instr_valid = 1'b1; ibus.instr = mk(4'h8, 3'd7, 3'd6, 3'd0, 3'd0);
    #1;
    total++;
    if (ibus.instr_ready !== 1'b0) begin bad++; $display("FAIL ldp_ready: got %b want 0", ibus.instr_ready); end
    @(negedge clk);
    ld_valid = 1'b0;
    rd_addr  = 3'd6;
    #1;
    total++;
    if (rd_data !== 16'h5A5A) begin bad++; $display("FAIL ldp_r6: got %h want 5a5a", rd_data); end
    total++;
    if (ibus.instr_ready !== 1'b1 || fu_fs !== 4'h0)
      begin bad++; $display("FAIL ldp_still_idle: got ready=%b fs=%h want 1/0", ibus.instr_ready, fu_fs); end
    @(negedge clk);
    ibus.instr_valid = 1'b0;
    total++;
    if (fu_fs !== 4'h8 || fu_a !== 16'h5A5A)
      begin bad++; $display("FAIL ldp_accept_next: got fs=%h a=%h want 8/5a5a", fu_fs, fu_a); end
    // load attempted while busy must be dropped
    load(3'd0, 16'h1111);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL ldp_done: got %b want 1", done); end
    @(negedge clk);
    rd_addr = 3'd7;
    #1;
    total++;
    if (rd_data !== 16'h5A5B) begin bad++; $display("FAIL ldp_r7: got %h want 5a5b", rd_data); end
    rd_addr = 3'd0;
    #1;
    total++;
    if (rd_data !== 16'h0000) begin bad++; $display("FAIL ldp_busy_load_dropped: got %h want 0000", rd_data); end
  endtask

  task automatic test_back_to_back;
    issue(mk(4'h1, 3'd7, 3'd7, 3'd7, 3'd0));
    @(negedge clk);
    @(negedge clk);
    issue(mk(4'h1, 3'd0, 3'd7, 3'd7, 3'd0));
    total++;
    if (fu_a !== 16'hB4B6) begin bad++; $display("FAIL b2b_operand: got %h want b4b6", fu_a); end
    @(negedge clk);
    @(negedge clk);
    rd_addr = 3'd0;
    #1;
    total++;
    if (rd_data !== 16'h696C) begin bad++; $display("FAIL b2b_r0: got %h want 696c", rd_data); end
    total++;
    if (flags !== 4'b1100) begin bad++; $display("FAIL b2b_flags: got %b want 1100", flags); end
  endtask

`ifdef FU_SEQ_COND_EN
  task automatic test_cond;
    load(3'd1, 16'hFFFF);
    load(3'd2, 16'h0001);
    issue(mk(4'h1, 3'd3, 3'd1, 3'd2, 3'd0));
    @(negedge clk);
    @(negedge clk);
    issue(mk(4'h8, 3'd6, 3'd6, 3'd0, 3'd2));
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL cond_false_pulse: got done=%b err=%b want 1/0", done, err); end
    @(negedge clk);
    rd_addr = 3'd6;
    #1;
    total++;
    if (rd_data !== 16'h5A5A || flags !== 4'b0101)
      begin bad++; $display("FAIL cond_false_hold: got r6=%h flags=%b want 5a5a/0101", rd_data, flags); end
    issue(mk(4'h8, 3'd6, 3'd6, 3'd0, 3'd1));
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (rd_data !== 16'h5A5B) begin bad++; $display("FAIL cond_true_r6: got %h want 5a5b", rd_data); end
    issue(mk(4'hF, 3'd6, 3'd6, 3'd0, 3'd7));
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL cond_never_illegal: got done=%b err=%b want 1/0", done, err); end
    @(negedge clk);
  endtask
`else
  task automatic test_cond_ignored;
    issue(mk(4'h8, 3'd6, 3'd6, 3'd0, 3'd7));
    @(negedge clk);
    @(negedge clk);
    rd_addr = 3'd6;
    #1;
    total++;
    if (rd_data !== 16'h5A5B) begin bad++; $display("FAIL cond_ignored_r6: got %h want 5a5b", rd_data); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    ibus.instr_valid = 1'b0; ibus.instr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_add;
    test_illegal;
    test_sub;
    test_swap;
    test_load_priority;
    test_back_to_back;
`ifdef FU_SEQ_COND_EN
    test_cond;
`else
    test_cond_ignored;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
